serial_adder: RTL
=================

Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor; the sequential successor to the combinational half adder.
- Processes WIDTH-bit operands one bit per cycle, LSB first, through a single full-adder cell with a registered carry.
- Adds carry-in, subtract mode, a signed overflow flag and a start/busy/done handshake.
- Used where area matters more than latency, for example in accumulators and checksum engines.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request to begin an operation; sampled only when busy=0.
- sub  input  1  0: a+b+cin; 1: a-b-cin. Latched on accepted start.
- cin  input  1  carry-in (add) or borrow-in (sub). Latched on accepted start.
- a  input  WIDTH  operand A. Latched on accepted start.
- b  input  WIDTH  operand B. Latched on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; sum, carry and overflow are valid from this cycle on.
- sum  output  WIDTH  result, held until the next completion.
- carry  output  1  raw carry-out of the MSB; in sub mode, 1 means no borrow.
- overflow  output  1  signed overflow = (carry into MSB) XOR (carry out of MSB).

Behaviour:
- States: IDLE, RUN, DONE. busy = (state==RUN). done = (state==DONE). Both are decoded from the registered state.
- Reset (rst_n=0, at any time, asynchronously):
  - state=IDLE, bit counter=0.
  - All operand, shift and carry registers = 0.
  - sum=0, carry=0, overflow=0, busy=0, done=0.
  - Reset mid-RUN aborts the operation; no done pulse is produced.
- Accept: start=1 at a rising edge k while in IDLE or DONE:
  - Latch opA=a, opB = b XOR {WIDTH{sub}}, carry register = cin XOR sub, counter=0.
  - Go to RUN.
- RUN, rising edges k+1 .. k+WIDTH:
  - At edge k+1+i, process bit i: s = opA[i] ^ opB[i] ^ c, and c = majority(opA[i], opB[i], c).
  - Shift s into the result shift register from the MSB end; increment the counter.
  - On the edge processing bit WIDTH-2, capture the carry going into the MSB.
- Last bit (edge k+WIDTH, counter == WIDTH-1):
  - Update the sum/carry/overflow output registers from the final values.
  - Go to DONE.
- Timing summary:
  - busy is high for exactly WIDTH cycles.
  - done is high for exactly one cycle, beginning at edge k+WIDTH.
  - Total latency from the accepting edge to done rising is WIDTH cycles.
- DONE: next edge goes to IDLE, or to RUN if start=1 (back-to-back operations, no idle gap).
- start while busy=1 is ignored; the latched operands are unaffected.
- a, b, sub and cin may change freely after the accepting edge.
- sum, carry and overflow never change except at completion or reset; intermediate bits are not visible.
- Arithmetic identities:
  - Sub mode computes a + ~b + ~cin, which equals a - b - cin modulo 2^WIDTH.
  - The result equals {carry, sum} = a + b + cin (add) or a + ~b + !cin (sub), at full WIDTH+1-bit precision.

Test Plan:
- WIDTH=8, add, a=8'h3C, b=8'h0F, cin=0 -> sum=8'h4B, carry=0, overflow=0. busy high 8 cycles; done one cycle at edge k+8.
- Add a=8'hFF, b=8'h01 -> sum=8'h00, carry=1, overflow=0. Then add a=8'h7F, b=8'h01 -> sum=8'h80, carry=0, overflow=1.
- Sub a=8'h05, b=8'h07, cin=0 -> sum=8'hFE, carry=0. Sub a=8'h80, b=8'h01 -> sum=8'h7F, carry=1, overflow=1. Sub a=8'h10, b=8'h01, cin=1 -> sum=8'h0E, carry=1.
- Add a=8'h10, b=8'h20, cin=1 -> sum=8'h31. Pulse start with new operands mid-RUN -> ignored, result unchanged. Assert start in the DONE cycle -> busy=1 on the next cycle and the second result is correct.
- Assert rst_n=0 after 4 RUN cycles -> all outputs 0 immediately and no done pulse. After release, a=8'h01, b=8'h02 -> sum=8'h03.
- WIDTH=4, exhaustive sweep of a, b, sub, cin (1024 operations) -> sum, carry and overflow match the WIDTH+1-bit arithmetic reference model every time.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor.
// Operands are consumed one bit per clock, LSB first, through a single
// full-adder cell whose carry lives in a register. A start/busy/done
// handshake frames each operation; results appear only at completion.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   // Counter only needs to index WIDTH bit positions.
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
   localparam logic [CW-1:0] MSB_IN_BIT = CW'(WIDTH - 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_reg, state_next;

   // Datapath registers
   logic [WIDTH-1:0] op_a_reg;      // shifted right as bits are consumed
   logic [WIDTH-1:0] op_b_reg;      // already conditioned for subtract
   logic             c_reg;         // running carry of the full-adder cell
   logic             c_msb_reg;     // carry going into the MSB position
   logic [WIDTH-1:0] shift_reg;     // partial result, filled from the MSB end
   logic [CW-1:0]    cnt_reg;       // index of the bit being processed

   // Output registers, updated only at completion
   logic [WIDTH-1:0] sum_reg;
   logic             carry_reg;
   logic             overflow_reg;

   // Combinational helpers
   logic [WIDTH-1:0] b_eff;
   logic             accept;
   logic             running;
   logic             last_bit;
   logic             s_bit;
   logic             c_next;

   // Subtraction is a + ~b + ~cin: invert B bit by bit when sub is set.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_b_cond
         assign b_eff[gi] = b[gi] ^ sub;
      end
   endgenerate

   // A new operation may begin from IDLE or directly out of DONE.
   assign accept   = start && (state_reg != RUN);
   assign running  = (state_reg == RUN);
   assign last_bit = running && (cnt_reg == LAST_BIT);

   // The single full-adder cell working on bit 0 of the shifting operands.
   assign s_bit  = op_a_reg[0] ^ op_b_reg[0] ^ c_reg;
   assign c_next = (op_a_reg[0] & op_b_reg[0]) |
                   (op_a_reg[0] & c_reg)       |
                   (op_b_reg[0] & c_reg);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: run for WIDTH cycles, pulse DONE, optionally chain.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (cnt_reg == LAST_BIT) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (start) begin
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operand latch on accept, then one bit of add/shift per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a_reg  <= '0;
         op_b_reg  <= '0;
         c_reg     <= 1'b0;
         c_msb_reg <= 1'b0;
         shift_reg <= '0;
         cnt_reg   <= '0;
      end else if (accept) begin
         op_a_reg  <= a;
         op_b_reg  <= b_eff;
         c_reg     <= cin ^ sub;
         c_msb_reg <= 1'b0;
         shift_reg <= '0;
         cnt_reg   <= '0;
      end else if (running) begin
         op_a_reg  <= op_a_reg >> 1;
         op_b_reg  <= op_b_reg >> 1;
         c_reg     <= c_next;
         shift_reg <= {s_bit, shift_reg[WIDTH-1:1]};
         cnt_reg   <= cnt_reg + CW'(1);
         if (cnt_reg == MSB_IN_BIT) begin
            c_msb_reg <= c_next;
         end
      end
   end

   // Publish the result only on the cycle that processes the MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_reg      <= '0;
         carry_reg    <= 1'b0;
         overflow_reg <= 1'b0;
      end else if (last_bit) begin
         sum_reg      <= {s_bit, shift_reg[WIDTH-1:1]};
         carry_reg    <= c_next;
         overflow_reg <= c_msb_reg ^ c_next;
      end
   end

   assign busy     = (state_reg == RUN);
   assign done     = (state_reg == DONE);
   assign sum      = sum_reg;
   assign carry    = carry_reg;
   assign overflow = overflow_reg;

endmodule
